mac_tx_arbiter: RTL and testbench
=================================

# mac_tx_arbiter

- Packet-level round-robin arbiter that shares the single 8-bit AXI-Stream MAC transmit port between NUM_SRC packet sources (e.g. the inference-result reply builder and the ARP responder).
- Locks the grant for a whole packet, from first beat to TLAST.
- A stall watchdog terminates a packet whose source stops supplying data: it emits a bad-frame beat (TLAST + TUSER) to the MAC, then silently drains the rest of that source's packet.
- Sits between the packet builders and the MAC TX interface, alongside ip_packet_rx on the receive side.

## Interface
Parameters:
- NUM_SRC, 2, number of requesting sources (≥2)
- AXI_S_DATA_WIDTH, 8, stream data width
- TIMEOUT_CYCLES, 16, consecutive cycles with the granted source's VALID low before abort (≥2)
- COUNTER_WIDTH, 16, width of the statistics counters

Ports (clock and reset first):
- ACLK  in  1  clock, all logic rising-edge
- ARESET  in  1  synchronous, active-high reset
- SRC_DATA  in  NUM_SRC*AXI_S_DATA_WIDTH  source i occupies bits [i*W +: W]
- SRC_VALID  in  NUM_SRC  per-source TVALID
- SRC_LAST  in  NUM_SRC  per-source TLAST
- SRC_TUSER  in  NUM_SRC  per-source TUSER (1 = bad frame), passed through
- SRC_READY  out  NUM_SRC  per-source TREADY
- MAC_TX_DATA  out  AXI_S_DATA_WIDTH  to MAC
- MAC_TX_VALID  out  1
- MAC_TX_LAST  out  1
- MAC_TX_TUSER  out  1
- MAC_TX_READY  in  1
- GRANT  out  NUM_SRC  one-hot current owner, 0 in IDLE
- BUSY  out  1  state != IDLE
- PKT_COUNT  out  COUNTER_WIDTH  packets completed normally
- ABORT_COUNT  out  COUNTER_WIDTH  packets aborted by watchdog

## Operation
- States: IDLE, PASS, ABORT, DRAIN. Registered: state, grant index g, last-served pointer, watchdog counter, PKT_COUNT, ABORT_COUNT.
- Reset:
  - state=IDLE; last-served = NUM_SRC-1, so source 0 wins first; counters 0.
  - All outputs 0: SRC_READY, MAC_TX_*, GRANT, BUSY.
- IDLE:
  - SRC_READY=0, MAC_TX_VALID=0.
  - If any SRC_VALID is high, choose the first requester scanning from last-served+1, wrapping modulo NUM_SRC.
  - Register g, clear the watchdog, go to PASS.
- PASS (combinational pass-through of source g):
  - MAC_TX_VALID/DATA/LAST/TUSER = source g signals.
  - SRC_READY[g] = MAC_TX_READY; all other SRC_READY = 0.
  - On a beat with SRC_LAST[g]: PKT_COUNT+1, last-served=g, go to IDLE.
  - Watchdog increments when SRC_VALID[g]=0 and clears whenever SRC_VALID[g]=1, so MAC backpressure never counts.
  - When the count reaches TIMEOUT_CYCLES with VALID still low, go to ABORT.
- ABORT:
  - Drive MAC_TX_VALID=1, DATA=0, LAST=1, TUSER=1; all SRC_READY=0.
  - On MAC_TX_READY: ABORT_COUNT+1, go to DRAIN.
- DRAIN:
  - SRC_READY[g]=1, MAC_TX_VALID=0.
  - Discard beats until a beat with SRC_LAST[g], then last-served=g, go to IDLE.
  - No timeout in DRAIN.
- Counters wrap modulo 2^COUNTER_WIDTH.
- Source TUSER=1 is forwarded unchanged and counts as a normal packet in PKT_COUNT.

## Timing
- Arbitration latency: a request seen in IDLE at cycle n gives GRANT/PASS at n+1. The first beat can transfer at n+1.
- Minimum gap between packets: 1 IDLE cycle. Back-to-back packets from the same source are allowed only if no other source is requesting in that IDLE cycle.
- A single-beat packet (VALID and LAST together) completes in one PASS cycle.
- Watchdog: abort triggers after exactly TIMEOUT_CYCLES consecutive PASS cycles with SRC_VALID[g]=0. The ABORT beat appears in the next cycle.
- A beat arriving in the cycle the count would hit the limit clears the watchdog; no abort occurs.
- Grant changes only in IDLE. A source dropping VALID mid-packet keeps its grant.
- Simultaneous requests in IDLE resolve strictly by the round-robin pointer.
- ARESET mid-packet forces IDLE the next cycle with all outputs 0. The MAC sees a truncated frame without TLAST, so the MAC must be reset together with this block.
- The MAC_TX path is combinational through PASS, so there is no added beat latency. The output register, if needed, lives in the MAC wrapper.

## Test plan
- Single source 0 sends a 5-byte packet 0x11..0x15 with LAST on 0x15 and MAC_TX_READY=1:
  - GRANT=01 one cycle after VALID.
  - MAC sees 5 beats in order; PKT_COUNT=1; back to IDLE.
- Both sources request continuously with 3-byte packets:
  - Grants alternate 0,1,0,1 with one IDLE cycle between packets.
  - After 4 packets, PKT_COUNT=4 and no beats interleave.
- MAC_TX_READY low for 40 cycles mid-packet while source VALID stays high:
  - No abort; data held stable.
  - Packet completes; ABORT_COUNT=0.
- Source 1 sends 2 beats, then VALID=0 for 16 cycles (TIMEOUT_CYCLES=16):
  - MAC sees one beat DATA=0x00, LAST=1, TUSER=1.
  - ABORT_COUNT=1.
  - The remaining 3 beats of source 1 are accepted with no MAC activity; then IDLE.
  - A stall of 15 cycles followed by a beat causes no abort.
- Assert ARESET for 1 cycle during beat 3 of a 6-beat packet:
  - All outputs 0 the next cycle and counters 0.
  - Source 0 wins the next arbitration even if source 1 was last served.

Source files
------------

// File: rtl/mac_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the 8-bit MAC transmit stream.
// A stall watchdog replaces a dead packet with a bad-frame beat and drains it.
module mac_tx_arbiter #(
  parameter int NUM_SRC          = 2,
  parameter int AXI_S_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 16,
  parameter int COUNTER_WIDTH    = 16
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [NUM_SRC*AXI_S_DATA_WIDTH-1:0] SRC_DATA,
  input  logic [NUM_SRC-1:0]                  SRC_VALID,
  input  logic [NUM_SRC-1:0]                  SRC_LAST,
  input  logic [NUM_SRC-1:0]                  SRC_TUSER,
  output logic [NUM_SRC-1:0]                  SRC_READY,
  output logic [AXI_S_DATA_WIDTH-1:0]         MAC_TX_DATA,
  output logic                                MAC_TX_VALID,
  output logic                                MAC_TX_LAST,
  output logic                                MAC_TX_TUSER,
  input  logic                                MAC_TX_READY,
  output logic [NUM_SRC-1:0]                  GRANT,
  output logic                                BUSY,
  output logic [COUNTER_WIDTH-1:0]            PKT_COUNT,
  output logic [COUNTER_WIDTH-1:0]            ABORT_COUNT
);

  localparam int W  = AXI_S_DATA_WIDTH;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] g;
  logic [IW-1:0] last_srv;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic [WW-1:0] wd;

  logic          g_valid;
  logic          g_last;
  logic          g_user;
  logic [W-1:0]  g_data;

  assign g_valid = SRC_VALID[g];
  assign g_last  = SRC_LAST[g];
  assign g_user  = SRC_TUSER[g];
  assign g_data  = SRC_DATA[g*W +: W];

  assign BUSY = (state != IDLE);

  // First requester after the last-served source, wrapping around.
  always_comb begin
    pick  = last_srv;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = IW'((int'(last_srv) + k) % NUM_SRC);
      if (!found && SRC_VALID[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    SRC_READY    = '0;
    GRANT        = '0;
    MAC_TX_VALID = 1'b0;
    MAC_TX_DATA  = '0;
    MAC_TX_LAST  = 1'b0;
    MAC_TX_TUSER = 1'b0;
    unique case (state)
      IDLE: begin
      end
      PASS: begin
        GRANT[g]     = 1'b1;
        SRC_READY[g] = MAC_TX_READY;
        MAC_TX_VALID = g_valid;
        MAC_TX_DATA  = g_data;
        MAC_TX_LAST  = g_last;
        MAC_TX_TUSER = g_user;
      end
      ABORT: begin
        GRANT[g]     = 1'b1;
        MAC_TX_VALID = 1'b1;
        MAC_TX_LAST  = 1'b1;
        MAC_TX_TUSER = 1'b1;
      end
      DRAIN: begin
        GRANT[g]     = 1'b1;
        SRC_READY[g] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      g           <= '0;
      last_srv    <= IW'(NUM_SRC - 1);
      wd          <= '0;
      PKT_COUNT   <= '0;
      ABORT_COUNT <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            g     <= pick;
            wd    <= '0;
            state <= PASS;
          end
        end
        PASS: begin
          // Only a silent source ages the watchdog, never backpressure.
          if (g_valid) begin
            wd <= '0;
            if (MAC_TX_READY && g_last) begin
              PKT_COUNT <= PKT_COUNT + COUNTER_WIDTH'(1);
              last_srv  <= g;
              state     <= IDLE;
            end
          end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            wd    <= '0;
            state <= ABORT;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        ABORT: begin
          if (MAC_TX_READY) begin
            ABORT_COUNT <= ABORT_COUNT + COUNTER_WIDTH'(1);
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (g_valid && g_last) begin
            last_srv <= g;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: per-source packet queues, per-source
// expected MAC streams and a rule-level round-robin/watchdog model.
module tb_mac_tx_arbiter;

  localparam int NS = 2;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            arst;
  logic [NS*W-1:0] sdata;
  logic [NS-1:0]   svalid;
  logic [NS-1:0]   slast;
  logic [NS-1:0]   suser;
  logic [NS-1:0]   sready;
  logic [W-1:0]    mdata;
  logic            mvalid;
  logic            mlast;
  logic            muser;
  logic            mready;
  logic [NS-1:0]   grant;
  logic            busy;
  logic [CW-1:0]   pkt;
  logic [CW-1:0]   abt;

  mac_tx_arbiter #(
    .NUM_SRC(NS),
    .AXI_S_DATA_WIDTH(W),
    .TIMEOUT_CYCLES(TO),
    .COUNTER_WIDTH(CW)
  ) dut (
    .ACLK(clk),
    .ARESET(arst),
    .SRC_DATA(sdata),
    .SRC_VALID(svalid),
    .SRC_LAST(slast),
    .SRC_TUSER(suser),
    .SRC_READY(sready),
    .MAC_TX_DATA(mdata),
    .MAC_TX_VALID(mvalid),
    .MAC_TX_LAST(mlast),
    .MAC_TX_TUSER(muser),
    .MAC_TX_READY(mready),
    .GRANT(grant),
    .BUSY(busy),
    .PKT_COUNT(pkt),
    .ABORT_COUNT(abt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // beat = {tuser, last, data}
  logic [9:0] src_q [NS][$];
  int         pre_q [NS][$];
  logic [9:0] exp_q [NS][$];

  int  m_last = NS - 1;
  int  m_pkt  = 0;
  int  m_abt  = 0;
  bit  pend   = 0;
  int  exp_g  = 0;
  int  rdy_block = 0;
  bit  rdy_rand  = 0;
  bit  prev_hold = 0;
  logic [9:0] prev_beat;
  int  idle_run = 0;
  logic [NS-1:0] grant_log [$];
  int  idle_gaps [$];

  function automatic int rr_pick(logic [NS-1:0] v);
    for (int k = 1; k <= NS; k++) begin
      if (v[(m_last + k) % NS]) return (m_last + k) % NS;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0 && pre_q[i][0] == 0) begin
        svalid[i] = 1'b1;
        {suser[i], slast[i], sdata[i*W +: W]} = src_q[i][0];
      end else begin
        svalid[i] = 1'b0;
        slast[i]  = 1'b0;
        suser[i]  = 1'b0;
        sdata[i*W +: W] = '0;
      end
    end
    if (rdy_block > 0) mready = 1'b0;
    else if (rdy_rand) mready = ($urandom_range(0, 3) != 0);
    else mready = 1'b1;
  endtask

  // One clock: drive at negedge, sample 1 ns later, advance model.
  task automatic step();
    logic [9:0] b;
    logic [9:0] e;
    int gi;
    drive();
    #1;
    if (prev_hold) begin
      n_tests++;
      if (mvalid !== 1'b1 || {muser, mlast, mdata} !== prev_beat) begin
        n_fail++;
        $display("FAIL hold: got v=%b beat=%h want v=1 beat=%h",
                 mvalid, {muser, mlast, mdata}, prev_beat);
      end
    end
    prev_hold = mvalid && !mready;
    prev_beat = {muser, mlast, mdata};
    if (pend) begin
      n_tests++;
      if (busy !== 1'b1 || grant !== NS'(1 << exp_g)) begin
        n_fail++;
        $display("FAIL rr_grant: got busy=%b grant=%b want busy=1 grant=%b",
                 busy, grant, NS'(1 << exp_g));
      end
      grant_log.push_back(grant);
      idle_gaps.push_back(idle_run);
      pend = 0;
    end
    if (!busy) begin
      idle_run++;
      if (|svalid) begin
        pend  = 1;
        exp_g = rr_pick(svalid);
      end
    end else begin
      idle_run = 0;
    end
    if (mvalid && mready) begin
      gi = 0;
      for (int i = 0; i < NS; i++) if (grant[i]) gi = i;
      n_tests++;
      if (busy !== 1'b1 || $countones(grant) != 1 || exp_q[gi].size() == 0) begin
        n_fail++;
        $display("FAIL mac_beat: got unexpected beat %h grant=%b want none",
                 {muser, mlast, mdata}, grant);
      end else begin
        e = exp_q[gi].pop_front();
        if ({muser, mlast, mdata} !== e) begin
          n_fail++;
          $display("FAIL mac_beat src%0d: got %h want %h",
                   gi, {muser, mlast, mdata}, e);
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (sready[i] && !grant[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_owner: got ready=%b grant=%b want ready only on owner",
                 sready, grant);
      end
      if (svalid[i] && sready[i]) begin
        b = src_q[i].pop_front();
        void'(pre_q[i].pop_front());
        if (b[8]) m_last = i;
      end else if (src_q[i].size() > 0 && pre_q[i][0] > 0) begin
        pre_q[i][0] = pre_q[i][0] - 1;
      end
    end
    if (rdy_block > 0) rdy_block--;
    @(negedge clk);
  endtask

  // Queue one packet; a stall of gap_len before beat gap_at (>0).
  task automatic send(int s, int base, int n, int gap_at, int gap_len, bit rnd_user);
    bit ab;
    logic u;
    logic [9:0] beat;
    ab = (gap_at > 0) && (gap_at < n) && (gap_len >= TO);
    for (int k = 0; k < n; k++) begin
      u = rnd_user ? 1'($urandom_range(0, 1)) : 1'b0;
      beat = {u, (k == n - 1), 8'(base + k)};
      src_q[s].push_back(beat);
      pre_q[s].push_back((gap_at > 0 && k == gap_at) ? gap_len : 0);
      if (!ab || k < gap_at) exp_q[s].push_back(beat);
    end
    if (ab) begin
      exp_q[s].push_back(10'h300);
      m_abt++;
    end else begin
      m_pkt++;
    end
  endtask

  task automatic run_until_idle(string name, int limit);
    int c;
    c = 0;
    while ((!all_empty() || busy) && c < limit) begin
      step();
      c++;
    end
    step();
    n_tests++;
    if (c >= limit || !all_empty() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got busy=%b empty=%0d after %0d cycles want idle",
               name, busy, all_empty(), c);
    end
  endtask

  task automatic check_counts(string name);
    n_tests++;
    if (pkt !== CW'(m_pkt)) begin
      n_fail++;
      $display("FAIL %s_pkt_count: got %0d want %0d", name, pkt, m_pkt);
    end
    n_tests++;
    if (abt !== CW'(m_abt)) begin
      n_fail++;
      $display("FAIL %s_abort_count: got %0d want %0d", name, abt, m_abt);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      pre_q[i].delete();
      exp_q[i].delete();
    end
    pend      = 0;
    prev_hold = 0;
    m_last    = NS - 1;
    m_pkt     = 0;
    m_abt     = 0;
  endtask

  task automatic check_zero(string name);
    n_tests++;
    if ({sready, mvalid, mlast, muser, mdata, grant, busy} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs: got rdy=%b v=%b l=%b u=%b d=%h g=%b busy=%b want 0",
               name, sready, mvalid, mlast, muser, mdata, grant, busy);
    end
    check_counts(name);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
    flush_model();
    check_zero("reset");
  endtask

  task automatic test_single();
    send(0, 8'h11, 5, 0, 0, 0);
    step();
    n_tests++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 01", grant);
    end
    run_until_idle("single", 100);
    check_counts("single");
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] first;
    grant_log.delete();
    idle_gaps.delete();
    first = NS'(1 << ((m_last + 1) % NS));
    send(0, 8'h20, 3, 0, 0, 0);
    send(0, 8'h23, 3, 0, 0, 0);
    send(1, 8'h40, 3, 0, 0, 0);
    send(1, 8'h43, 3, 0, 0, 0);
    run_until_idle("b2b", 200);
    n_tests++;
    if (grant_log.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_grants: got %0d grants want 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (grant_log[i] !== ((i % 2 == 0) ? first : ~first)) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got %b want %b", i, grant_log[i],
                   (i % 2 == 0) ? first : ~first);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_tests++;
        if (idle_gaps[i] != 1) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got %0d idle cycles want 1", i, idle_gaps[i]);
        end
      end
    end
    check_counts("b2b");
  endtask

  task automatic test_backpressure();
    int c;
    send(0, 8'h60, 6, 0, 0, 0);
    c = 0;
    while (src_q[0].size() > 3 && c < 50) begin
      step();
      c++;
    end
    rdy_block = 40;
    run_until_idle("bp", 300);
    check_counts("bp");
  endtask

  task automatic test_abort();
    send(1, 8'h80, 5, 2, TO, 0);
    run_until_idle("abort", 300);
    check_counts("abort");
    n_tests++;
    if (m_last != 1) begin
      n_fail++;
      $display("FAIL abort_drain: got last=%0d want 1", m_last);
    end
    send(1, 8'h90, 5, 2, TO - 1, 0);
    run_until_idle("no_abort", 300);
    check_counts("no_abort");
  endtask

  task automatic test_random();
    int np;
    int s;
    int n;
    int ga;
    int gl;
    rdy_rand = 1;
    for (int b = 0; b < 12; b++) begin
      np = $urandom_range(2, 6);
      for (int p = 0; p < np; p++) begin
        s  = $urandom_range(0, NS - 1);
        n  = $urandom_range(1, 6);
        ga = 0;
        gl = 0;
        if (n > 1) begin
          ga = $urandom_range(1, n - 1);
          if ($urandom_range(0, 2) == 0) gl = TO - 2 + $urandom_range(0, 4);
          else gl = $urandom_range(0, 4);
        end
        send(s, $urandom_range(0, 255), n, ga, gl, 1);
      end
      run_until_idle("random", 3000);
    end
    rdy_rand = 0;
    check_counts("random");
  endtask

  task automatic test_reset_mid();
    int c;
    send(1, 8'hA0, 1, 0, 0, 0);
    run_until_idle("rst_pre", 100);
    send(0, 8'hB0, 6, 0, 0, 0);
    c = 0;
    while (src_q[0].size() > 4 && c < 50) begin
      step();
      c++;
    end
    arst = 1'b1;
    step();
    arst = 1'b0;
    flush_model();
    check_zero("reset_mid");
    grant_log.delete();
    send(1, 8'hC0, 2, 0, 0, 0);
    send(0, 8'hD0, 2, 0, 0, 0);
    run_until_idle("rst_post", 100);
    n_tests++;
    if (grant_log.size() == 0 || grant_log[0] !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_rr: got first grant %b want 01",
               (grant_log.size() == 0) ? 2'b00 : grant_log[0]);
    end
    check_counts("rst_post");
  endtask

  initial begin
    arst   = 1'b1;
    sdata  = '0;
    svalid = '0;
    slast  = '0;
    suser  = '0;
    mready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
